// File: rtl/pipelined_reduce_calc_pkg.sv
// Shared types for the pipelined reduce calculator: operation codes and the
// per-stage control word carried alongside each partial result.
package calc_pkg;

  localparam int unsigned CALC_OP_W = 2;

  typedef enum logic [CALC_OP_W-1:0] {
    CALC_ADD = 2'b00,
    CALC_SUB = 2'b01,
    CALC_MAX = 2'b10,
    CALC_MIN = 2'b11
  } calc_op_e;

  typedef struct packed {
    logic     valid;
    calc_op_e op;
    logic     ovf;
  } calc_stage_t;

endpackage

// File: rtl/pipelined_reduce_calc_alu_stage.sv
// One combine step of the reduction: y = a (op) b, with carry/borrow flag.
// With PIPELINED_REDUCE_SATURATE_EN defined, ADD clamps to all-ones on carry
// and SUB clamps to zero on borrow; otherwise results wrap.
module calc_alu_stage
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  calc_op_e         op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};

  // Select the operation result and its overflow/borrow flag.
  always_comb begin
    y_o   = '0;
    ovf_o = 1'b0;
    case (op_i)
      CALC_ADD: begin
        ovf_o = sum[WIDTH];
`ifdef PIPELINED_REDUCE_SATURATE_EN
        y_o   = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
        y_o   = sum[WIDTH-1:0];
`endif
      end
      CALC_SUB: begin
        ovf_o = diff[WIDTH];
`ifdef PIPELINED_REDUCE_SATURATE_EN
        y_o   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        y_o   = diff[WIDTH-1:0];
`endif
      end
      CALC_MAX: y_o = (a_i >= b_i) ? a_i : b_i;
      CALC_MIN: y_o = (a_i <= b_i) ? a_i : b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_reduce_calc.sv
// Reduces NUM_OPS packed WIDTH-bit operands (op0 at the MSBs) through a
// linear chain of NUM_OPS-1 registered combine stages with valid/ready flow
// control. Optional macro: PIPELINED_REDUCE_SATURATE_EN (saturating ADD/SUB).
module pipelined_reduce_calc
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OPS = 4
) (
  input  logic                       one_MHz_clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CALC_OP_W-1:0]       in_op,
  input  logic [NUM_OPS*WIDTH-1:0]   instruction,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic                       out_ovf
);

  logic             stall;
  logic [WIDTH-1:0] result_q;
  logic             out_ovf_q;
  logic             out_valid_q;

  // Whole pipeline freezes while the output beat waits for the consumer.
  assign stall    = out_valid_q && !out_ready;
  assign in_ready = !stall;

  // Stage k combines the running partial with operand k. Each non-final stage
  // also forwards the operands not yet consumed, so the forwarded vector
  // shrinks by one operand per stage.
  for (genvar k = 1; k < NUM_OPS; k++) begin : g_stage
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    calc_op_e         op;
    logic             valid_in;
    logic             ovf_in;
    logic             ovf;

    if (k == 1) begin : g_src
      assign a        = instruction[NUM_OPS*WIDTH-1 -: WIDTH];
      assign b        = instruction[(NUM_OPS-1)*WIDTH-1 -: WIDTH];
      assign op       = calc_op_e'(in_op);
      assign valid_in = in_valid;
      assign ovf_in   = 1'b0;
    end else begin : g_src
      assign a        = g_stage[k-1].g_reg.part_q;
      assign b        = g_stage[k-1].g_reg.rem_q[(NUM_OPS-k)*WIDTH-1 -: WIDTH];
      assign op       = g_stage[k-1].g_reg.ctrl_q.op;
      assign valid_in = g_stage[k-1].g_reg.ctrl_q.valid;
      assign ovf_in   = g_stage[k-1].g_reg.ctrl_q.ovf;
    end

    calc_alu_stage #(
      .WIDTH (WIDTH)
    ) u_alu (
      .a_i   (a),
      .b_i   (b),
      .op_i  (op),
      .y_o   (y),
      .ovf_o (ovf)
    );

    if (k < NUM_OPS - 1) begin : g_reg
      localparam int unsigned REM_W = (NUM_OPS - 1 - k) * WIDTH;

      logic [WIDTH-1:0] part_q;
      logic [REM_W-1:0] rem_d;
      logic [REM_W-1:0] rem_q;
      calc_stage_t      ctrl_d;
      calc_stage_t      ctrl_q;

      if (k == 1) begin : g_rem
        assign rem_d = instruction[REM_W-1:0];
      end else begin : g_rem
        assign rem_d = g_stage[k-1].g_reg.rem_q[REM_W-1:0];
      end

      assign ctrl_d = '{valid: valid_in, op: op, ovf: ovf_in | ovf};

      // Intermediate pipeline register, held while stalled.
      always_ff @(posedge one_MHz_clk or posedge reset) begin
        if (reset) begin
          part_q <= '0;
          rem_q  <= '0;
          ctrl_q <= '0;
        end else if (!stall) begin
          part_q <= y;
          rem_q  <= rem_d;
          ctrl_q <= ctrl_d;
        end
      end
    end
  end

  // Final stage doubles as the output register.
  always_ff @(posedge one_MHz_clk or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      result_q    <= g_stage[NUM_OPS-1].y;
      out_ovf_q   <= g_stage[NUM_OPS-1].ovf_in | g_stage[NUM_OPS-1].ovf;
      out_valid_q <= g_stage[NUM_OPS-1].valid_in;
    end
  end

  assign result    = result_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/pipelined_reduce_calc.md
Name: pipelined_reduce_calc

Overview:
- Parametrised successor of the fixed 4-operand 8-bit pipelined adder.
- Reduces NUM_OPS packed operands of WIDTH bits to one result through a linear chain of NUM_OPS-1 registered combine stages. Supported operations: ADD, SUB, MAX, MIN.
- Adds valid/ready flow control on both sides and an overflow flag.
- Sits between the instruction source and the result display/consumer; runs on the divided 1 MHz clock.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- NUM_OPS, 4, operands per instruction (≥2); pipeline depth is NUM_OPS-1.

Ports:
- one_MHz_clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  instruction/in_op are valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_op  in  2  operation: 00 ADD, 01 SUB, 10 MAX, 11 MIN.
- instruction  in  NUM_OPS*WIDTH  packed operands; op0 at the MSBs, op(NUM_OPS-1) at the LSBs.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result beat.
- result  out  WIDTH  reduced result.
- out_ovf  out  1  overflow/borrow occurred in any stage of this beat.

Behaviour:
- Interface declaration: reset reset, asynchronous, active-high; clock one_MHz_clk.
- Reset values: all stage valid bits 0, so out_valid=0. result=0, out_ovf=0, in_ready=1 once reset deasserts.
- Accept: a beat is accepted on a rising edge where in_valid && in_ready. Stage 1 then registers op0∘op1, the remaining operands, op, and ovf.
- Stage k (2..NUM_OPS-1) registers partial∘op(k). Stage NUM_OPS-1 is the output register driving result/out_ovf/out_valid.
- Latency: a beat accepted at edge E is presented with out_valid=1 after edge E+NUM_OPS-2 (NUM_OPS-1 registered stages). Throughput is one beat per cycle.
- Stall rule: stall = out_valid && !out_ready.
  - While stalled, every stage holds its content (global enable) and in_ready=0.
  - in_ready = !stall, a combinational function of registered out_valid and out_ready.
  - Bubbles (invalid stages) are not compacted.
- Output beat completes on an edge with out_valid && out_ready. result/out_ovf must stay stable while out_valid && !out_ready.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - ADD: partial+op; the carry out of the stage is ORed into ovf.
  - SUB: partial-op, i.e. op0 minus all the others in order; a borrow is ORed into ovf.
  - MAX/MIN: unsigned compare; ovf is always 0.
- The op code travels with its beat, so mixed ops back-to-back are legal.
- Simultaneous output accept and input accept in the same cycle is legal and needs no bubble.
- in_valid while in_ready=0: the beat is not taken. The source must hold it until accepted.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous). No stale beat may emerge after release.

Optional Feature:
- Macro: PIPELINED_REDUCE_SATURATE_EN.
- Defined: ADD clamps a stage result to 2^WIDTH-1 on carry; SUB clamps it to 0 on borrow. Subsequent stages operate on the clamped value, and out_ovf is still reported.
- Undefined: wrap-around as above. The saturation logic is absent from the netlist.

Decomposition:
- Package calc_pkg:
  - calc_op_e enum (CALC_ADD=2'b00, CALC_SUB, CALC_MAX, CALC_MIN).
  - Localparam for the op field width.
  - Stage struct typedef pattern {valid, op, ovf} used by the pipeline registers.
- Sub-module calc_alu_stage: purely combinational, parameter WIDTH. Inputs a, b, op; outputs y, ovf; contains the saturation ifdef. Instantiated NUM_OPS-1 times via generate.

Test Plan (WIDTH=8, NUM_OPS=4):
- ADD 0x01,0x02,0x03,0x04, accepted at edge E, out_ready=1 → result=0x0A, out_ovf=0, out_valid high after edge E+2.
- ADD 0xFF,0x01,0x00,0x00 → result=0x00, out_ovf=1. With PIPELINED_REDUCE_SATURATE_EN → result=0xFF, out_ovf=1.
- SUB 0x10,0x01,0x02,0x03 → 0x0A, ovf=0. SUB 0x00,0x01,0x00,0x00 → 0xFF, ovf=1 (0x00 with SATURATE_EN).
- Back-to-back MAX 0x05,0xF0,0x30,0x07 then MIN with the same operands → 0xF0 then 0x05 on consecutive cycles, ovf=0.
- Four consecutive beats, with out_ready held low for 2 cycles while the first result is valid → in_ready=0 during the stall, result held stable, all four results delivered in order with none lost or duplicated.
- Two beats in flight, reset pulsed for 1 cycle → out_valid=0 at once, and no result emerges for 5 cycles after release.
